// File: rtl/axi4_wr_arbiter_if.sv
// Bundle of every signal between the write arbiter, the NUM_M stream
// writers on its upstream side and the single AXI4 write slave downstream.
// The arbiter takes the "master" modport (it masters the shared port); the
// environment (writers plus slave) takes the "slave" modport.
interface axi4_wr_arbiter_if #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);

   logic [NUM_M-1:0]        m_awvalid;
   logic [NUM_M-1:0]        m_awready;
   logic [NUM_M*ADDR_W-1:0] m_awaddr;
   logic [NUM_M*LEN_W-1:0]  m_awlen;
   logic [NUM_M-1:0]        m_wvalid;
   logic [NUM_M-1:0]        m_wready;
   logic [NUM_M*DATA_W-1:0] m_wdata;
   logic [NUM_M-1:0]        m_wlast;
   logic [NUM_M-1:0]        m_bvalid;
   logic [NUM_M-1:0]        m_bready;

   logic                    s_awvalid;
   logic                    s_awready;
   logic [ADDR_W-1:0]       s_awaddr;
   logic [LEN_W-1:0]        s_awlen;
   logic                    s_wvalid;
   logic                    s_wready;
   logic [DATA_W-1:0]       s_wdata;
   logic                    s_wlast;
   logic                    s_bvalid;
   logic                    s_bready;

   modport master (
      input  m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
      input  s_awready, s_wready, s_bvalid,
      output m_awready, m_wready, m_bvalid,
      output s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wlast, s_bready
   );

   modport slave (
      output m_awvalid, m_awaddr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
      output s_awready, s_wready, s_bvalid,
      input  m_awready, m_wready, m_bvalid,
      input  s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wdata, s_wlast, s_bready
   );

endinterface

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter that shares one AXI4 write port among NUM_M burst
// writers. A winner owns the port for a whole transaction (AW, every W beat,
// B) and only then does priority rotate. Nothing is buffered: the shared
// outputs are muxed straight from the granted master.
module axi4_wr_arbiter #(
   parameter int  NUM_M  = 2,
   parameter int  ADDR_W = 32,
   parameter int  DATA_W = 32,
   parameter int  LEN_W  = 8,
   localparam int ID_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
   input  logic                clk,
   input  logic                reset,
   axi4_wr_arbiter_if.master   bus,
   output logic [ID_W-1:0]     grant_id,
   output logic                busy,
   output logic                err_wlast
);

   typedef enum logic [1:0] {
      IDLE,
      AW,
      W,
      B
   } state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]  lastGnt_q, lastGnt_d;
   logic [LEN_W:0]   beatCnt_q, beatCnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             err_q, err_d;

   logic [ID_W-1:0]  pick;
   logic [ID_W-1:0]  cand;
   logic             anyReq;

   // Round-robin search: walk from the farthest candidate to the nearest one
   // after lastGnt so the nearest requester overwrites earlier hits and wins.
   always_comb begin
      pick   = lastGnt_q;
      cand   = '0;
      anyReq = 1'b0;
      for (int k = NUM_M; k >= 1; k--) begin
         cand = ID_W'((int'(lastGnt_q) + k) % NUM_M);
         if (bus.m_awvalid[cand]) begin
            pick   = cand;
            anyReq = 1'b1;
         end
      end
   end

   // Payload muxes follow the current grant regardless of state; the valid
   // qualifiers below decide when they actually mean anything.
   always_comb begin
      bus.s_awaddr = '0;
      bus.s_awlen  = '0;
      bus.s_wdata  = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (gnt_q == ID_W'(i)) begin
            bus.s_awaddr = bus.m_awaddr[i*ADDR_W +: ADDR_W];
            bus.s_awlen  = bus.m_awlen[i*LEN_W +: LEN_W];
            bus.s_wdata  = bus.m_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.s_wlast = bus.m_wlast[gnt_q];

   // Next-state logic plus handshake routing; only the granted master ever
   // sees a ready or bvalid, and each channel is open only in its own state.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt_q;
      lastGnt_d     = lastGnt_q;
      beatCnt_d     = beatCnt_q;
      len_d         = len_q;
      err_d         = err_q;
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
      bus.s_bready  = 1'b0;
      bus.m_awready = '0;
      bus.m_wready  = '0;
      bus.m_bvalid  = '0;

      case (state_q)
         IDLE: begin
            if (anyReq) begin
               gnt_d     = pick;
               beatCnt_d = '0;
               state_d   = AW;
            end
         end
         AW: begin
            bus.s_awvalid        = bus.m_awvalid[gnt_q];
            bus.m_awready[gnt_q] = bus.s_awready;
            if (bus.m_awvalid[gnt_q] && bus.s_awready) begin
               len_d   = bus.s_awlen;
               state_d = W;
            end
         end
         W: begin
            bus.s_wvalid        = bus.m_wvalid[gnt_q];
            bus.m_wready[gnt_q] = bus.s_wready;
            if (bus.m_wvalid[gnt_q] && bus.s_wready) begin
               beatCnt_d = beatCnt_q + 1'b1;
               if (bus.s_wlast && (beatCnt_q != {1'b0, len_q})) begin
                  err_d = 1'b1;
               end
               if (!bus.s_wlast && (beatCnt_q == {1'b0, len_q})) begin
                  err_d = 1'b1;
               end
               if (bus.s_wlast) begin
                  state_d = B;
               end
            end
         end
         B: begin
            bus.m_bvalid[gnt_q] = bus.s_bvalid;
            bus.s_bready        = bus.m_bready[gnt_q];
            if (bus.s_bvalid && bus.m_bready[gnt_q]) begin
               lastGnt_d = gnt_q;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset parks lastGnt on the top master so master 0 is
   // the first one served.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         lastGnt_q <= ID_W'(NUM_M - 1);
         beatCnt_q <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         lastGnt_q <= lastGnt_d;
         beatCnt_q <= beatCnt_d;
         len_q     <= len_d;
         err_q     <= err_d;
      end
   end

   assign grant_id  = gnt_q;
   assign busy      = (state_q != IDLE);
   assign err_wlast = err_q;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Bench for the two-master write arbiter: a cycle-by-cycle vector table for
// single bursts, the wlast error, and a long B stall, followed by hand-written
// sequences for grant rotation, W back-pressure and a mid-burst reset.
module tb_axi4_wr_arbiter;

   localparam int NUM_M  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   localparam logic [31:0] ADDR0 = 32'h8000_0000;
   localparam logic [31:0] ADDR1 = 32'h9000_0000;

   logic clk = 1'b0;
   logic reset;
   logic grantId;
   logic busy;
   logic errWlast;

   int errors = 0;
   int checks = 0;

   axi4_wr_arbiter_if #(
      .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
   ) bus ();

   axi4_wr_arbiter #(
      .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .grant_id (grantId),
      .busy     (busy),
      .err_wlast(errWlast)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus and the outputs expected during that cycle.
   // exp packs {busy, grant_id, s_awvalid, s_wvalid, s_wlast&s_wvalid,
   // s_bready, m_awready[1:0], m_wready[1:0], m_bvalid[1:0], err_wlast}.
   typedef struct {
      logic       rst;
      logic [1:0] awv;
      logic [7:0] len;
      logic [1:0] wv;
      logic [1:0] wl;
      logic [1:0] br;
      logic       sawr;
      logic       swr;
      logic       sbv;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rst, input logic [1:0] awv,
                              input logic [7:0] len, input logic [1:0] wv,
                              input logic [1:0] wl, input logic [1:0] br,
                              input logic sawr, input logic swr,
                              input logic sbv, input logic [12:0] exp);
      vec_t r;
      r.rst = rst; r.awv = awv; r.len = len; r.wv = wv; r.wl = wl;
      r.br = br; r.sawr = sawr; r.swr = swr; r.sbv = sbv; r.exp = exp;
      return r;
   endfunction

   function automatic logic [12:0] observed();
      return {busy, grantId, bus.s_awvalid, bus.s_wvalid,
              bus.s_wlast & bus.s_wvalid, bus.s_bready,
              bus.m_awready, bus.m_wready, bus.m_bvalid, errWlast};
   endfunction

   function automatic logic [31:0] beatData(input int m, input int b);
      return ((m == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(b);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      bus.m_awvalid = '0;
      bus.m_awaddr  = {ADDR1, ADDR0};
      bus.m_awlen   = '0;
      bus.m_wvalid  = '0;
      bus.m_wdata   = '0;
      bus.m_wlast   = '0;
      bus.m_bready  = '0;
      bus.s_awready = 1'b0;
      bus.s_wready  = 1'b0;
      bus.s_bvalid  = 1'b0;
   endtask

   // Drive one table row, compare mid-cycle, then step past the edge.
   task automatic applyStimulus(input vec_t t, input int idx);
      reset         = t.rst;
      bus.m_awvalid = t.awv;
      bus.m_awlen   = {t.len, t.len};
      bus.m_wvalid  = t.wv;
      bus.m_wlast   = t.wl;
      bus.m_bready  = t.br;
      bus.s_awready = t.sawr;
      bus.s_wready  = t.swr;
      bus.s_bvalid  = t.sbv;
      @(negedge clk);
      checkOutput($sformatf("vec%0d", idx), 64'(observed()), 64'(t.exp));
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      clearInputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Serve one transaction from master m (caller already raised its awvalid)
   // with an ideal slave, optionally toggling s_wready 1,0,1,0 in W.
   task automatic runBurst(input string tag, input int m, input int nbeats,
                           input bit toggleReady);
      logic [1:0] mine;
      logic       tgl;
      bit         hs;
      int         cyc;
      mine          = (m == 0) ? 2'b01 : 2'b10;
      tgl           = 1'b1;
      bus.s_awready = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!bus.s_awvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, " aw seen"}, 64'(cyc < 20), 64'd1);
      checkOutput({tag, " grant"}, 64'(grantId), 64'(m));
      checkOutput({tag, " awaddr"}, 64'(bus.s_awaddr), 64'((m == 0) ? ADDR0 : ADDR1));
      checkOutput({tag, " awready"}, 64'(bus.m_awready), 64'(mine));
      @(posedge clk);
      #1;
      bus.m_awvalid = bus.m_awvalid & ~mine;
      bus.s_awready = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         bus.m_wvalid = mine;
         bus.m_wlast  = (b == nbeats - 1) ? mine : 2'b00;
         bus.m_wdata  = (m == 0) ? {32'h0, beatData(0, b)} : {beatData(1, b), 32'h0};
         hs  = 1'b0;
         cyc = 0;
         while (!hs && cyc < 16) begin
            if (toggleReady) begin
               bus.s_wready = tgl;
               tgl = ~tgl;
            end else begin
               bus.s_wready = 1'b1;
            end
            @(negedge clk);
            checkOutput({tag, " wready"}, 64'(bus.m_wready), 64'(bus.s_wready ? mine : 2'b00));
            if (bus.s_wvalid && bus.s_wready) begin
               checkOutput({tag, $sformatf(" wdata%0d", b)}, 64'(bus.s_wdata), 64'(beatData(m, b)));
               checkOutput({tag, $sformatf(" wlast%0d", b)}, 64'(bus.s_wlast), 64'(b == nbeats - 1));
               hs = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
         end
         checkOutput({tag, $sformatf(" beat%0d done", b)}, 64'(hs), 64'd1);
      end
      bus.m_wvalid = '0;
      bus.m_wlast  = '0;
      bus.s_wready = 1'b0;
      bus.s_bvalid = 1'b1;
      bus.m_bready = mine;
      @(negedge clk);
      checkOutput({tag, " bvalid"}, 64'(bus.m_bvalid), 64'(mine));
      checkOutput({tag, " no aw in B"}, 64'(bus.s_awvalid), 64'd0);
      @(posedge clk);
      #1;
      bus.s_bvalid = 1'b0;
      bus.m_bready = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset check, then T1 single 4-beat burst from m0 (busy for 7 cycles).
      vecs.push_back(v(1, 2'b00, 8'd3, 2'b00, 2'b00, 2'b00, 0, 0, 0, 13'b0_0_0_0_0_0_00_00_00_0));
      vecs.push_back(v(0, 2'b01, 8'd3, 2'b00, 2'b00, 2'b00, 1, 0, 0, 13'b0_0_0_0_0_0_00_00_00_0));
      vecs.push_back(v(0, 2'b01, 8'd3, 2'b00, 2'b00, 2'b00, 1, 0, 0, 13'b1_0_1_0_0_0_01_00_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b01, 2'b00, 2'b00, 1, 1, 0, 13'b1_0_0_1_0_0_00_01_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b01, 2'b00, 2'b00, 1, 1, 0, 13'b1_0_0_1_0_0_00_01_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b01, 2'b00, 2'b00, 1, 1, 0, 13'b1_0_0_1_0_0_00_01_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b01, 2'b01, 2'b00, 1, 1, 0, 13'b1_0_0_1_1_0_00_01_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b00, 2'b00, 2'b01, 1, 1, 0, 13'b1_0_0_0_0_1_00_00_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b00, 2'b00, 2'b01, 1, 1, 1, 13'b1_0_0_0_0_1_00_00_01_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_0_0_0_0_0_00_00_00_0));
      // T4: early wlast on beat 2 of a len-3 burst; burst still ends, B routed.
      vecs.push_back(v(0, 2'b01, 8'd3, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_0_0_0_0_0_00_00_00_0));
      vecs.push_back(v(0, 2'b01, 8'd3, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b1_0_1_0_0_0_01_00_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b01, 2'b00, 2'b00, 1, 1, 0, 13'b1_0_0_1_0_0_00_01_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b01, 2'b01, 2'b00, 1, 1, 0, 13'b1_0_0_1_1_0_00_01_00_0));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b00, 2'b00, 2'b01, 1, 1, 1, 13'b1_0_0_0_0_1_00_00_01_1));
      vecs.push_back(v(0, 2'b00, 8'd3, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_0_0_0_0_0_00_00_00_1));
      // T6: both request, m1 wins after m0; B stalls 5 cycles on m_bready[1]=0.
      vecs.push_back(v(0, 2'b11, 8'd0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_0_0_0_0_0_00_00_00_1));
      vecs.push_back(v(0, 2'b11, 8'd0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b1_1_1_0_0_0_10_00_00_1));
      vecs.push_back(v(0, 2'b01, 8'd0, 2'b11, 2'b11, 2'b00, 1, 1, 0, 13'b1_1_0_1_1_0_00_10_00_1));
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(v(0, 2'b01, 8'd0, 2'b00, 2'b00, 2'b01, 1, 1, 1, 13'b1_1_0_0_0_0_00_00_10_1));
      end
      vecs.push_back(v(0, 2'b01, 8'd0, 2'b00, 2'b00, 2'b10, 1, 1, 1, 13'b1_1_0_0_0_1_00_00_10_1));
      vecs.push_back(v(0, 2'b01, 8'd0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_1_0_0_0_0_00_00_00_1));
      vecs.push_back(v(0, 2'b01, 8'd0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b1_0_1_0_0_0_01_00_00_1));
      vecs.push_back(v(0, 2'b00, 8'd0, 2'b01, 2'b01, 2'b00, 1, 1, 0, 13'b1_0_0_1_1_0_00_01_00_1));
      vecs.push_back(v(0, 2'b00, 8'd0, 2'b00, 2'b00, 2'b01, 1, 1, 1, 13'b1_0_0_0_0_1_00_00_01_1));
      // Reset clears the sticky flag; then a late-wlast burst sets it again.
      vecs.push_back(v(1, 2'b00, 8'd0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_0_0_0_0_0_00_00_00_1));
      vecs.push_back(v(0, 2'b10, 8'd1, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_0_0_0_0_0_00_00_00_0));
      vecs.push_back(v(0, 2'b10, 8'd1, 2'b00, 2'b00, 2'b00, 0, 1, 0, 13'b1_1_1_0_0_0_00_00_00_0));
      vecs.push_back(v(0, 2'b10, 8'd1, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b1_1_1_0_0_0_10_00_00_0));
      vecs.push_back(v(0, 2'b00, 8'd1, 2'b10, 2'b00, 2'b00, 1, 1, 0, 13'b1_1_0_1_0_0_00_10_00_0));
      vecs.push_back(v(0, 2'b00, 8'd1, 2'b10, 2'b00, 2'b00, 1, 1, 0, 13'b1_1_0_1_0_0_00_10_00_0));
      vecs.push_back(v(0, 2'b00, 8'd1, 2'b10, 2'b10, 2'b00, 1, 1, 0, 13'b1_1_0_1_1_0_00_10_00_1));
      vecs.push_back(v(0, 2'b00, 8'd1, 2'b00, 2'b00, 2'b10, 1, 1, 1, 13'b1_1_0_0_0_1_00_00_10_1));
      vecs.push_back(v(0, 2'b00, 8'd1, 2'b00, 2'b00, 2'b00, 1, 1, 0, 13'b0_1_0_0_0_0_00_00_00_1));

      doReset();
      #1;
      reset = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i], i);
      end

      // T2: both masters request together twice -> grants 0,1,0,1.
      doReset();
      for (int r = 0; r < 2; r++) begin
         bus.m_awvalid = 2'b11;
         bus.m_awlen   = '0;
         runBurst($sformatf("T2r%0d m0", r), 0, 1, 1'b0);
         runBurst($sformatf("T2r%0d m1", r), 1, 1, 1'b0);
      end

      // T3: m1 len-3 burst under s_wready 1,0,1,0 back-pressure.
      bus.m_awvalid = 2'b10;
      bus.m_awlen   = {8'd3, 8'd3};
      runBurst("T3", 1, 4, 1'b1);
      @(negedge clk);
      checkOutput("T3 err clean", 64'(errWlast), 64'd0);
      @(posedge clk);
      #1;

      // T5: reset lands during beat 2 of a 4-beat m0 burst.
      doReset();
      bus.m_awvalid = 2'b01;
      bus.m_awlen   = {8'd3, 8'd3};
      bus.s_awready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.m_awvalid = 2'b00;
      bus.m_wvalid  = 2'b01;
      bus.m_wdata   = {32'h0, beatData(0, 0)};
      bus.s_wready  = 1'b1;
      @(posedge clk);
      #1;
      bus.m_wdata = {32'h0, beatData(0, 1)};
      @(negedge clk);
      checkOutput("T5 mid W", 64'({busy, bus.s_wvalid}), 64'(2'b11));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clearInputs();
      @(negedge clk);
      checkOutput("T5 after reset", 64'(observed()), 64'd0);
      @(posedge clk);
      #1;
      bus.m_awvalid = 2'b10;
      bus.m_awlen   = {8'd1, 8'd1};
      runBurst("T5 m1", 1, 2, 1'b0);
      @(negedge clk);
      checkOutput("T5 idle end", 64'({busy, errWlast}), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
